// File: rtl/uart_rx_frame_ctrl_if.sv
// Frame controller bus: shifter frame input, host-side byte drain, and status.
// Build option RX_PARITY_EN (in the controller) decides whether parity_err is live.
interface uart_rx_frame_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             frame_valid;
  logic [10:0]      frame_data;
  logic             rd_ready;
  logic             err_clr;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  modport master (
    output frame_valid, frame_data, rd_ready, err_clr,
    input  rd_data, rd_valid, fifo_count, frame_err, parity_err, overrun, busy
  );

  modport slave (
    input  frame_valid, frame_data, rd_ready, err_clr,
    output rd_data, rd_valid, fifo_count, frame_err, parity_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame checker + byte FIFO; frame bytes land 3 cycles after the frame_valid rise,
// no bypass, host drains on rd_valid && rd_ready. Macro RX_PARITY_EN enables parity checking.
module uart_rx_frame_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input logic              baud_clk,
  input logic              rst_n,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_frame_ctrl: FIFO_DEPTH must be a power of two in 2..16, PARITY_ODD 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            fv_q, fv_d;
  logic [10:0]     shadow_q, shadow_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            frame_evt;
  logic            start_bad, stop_bad, par_bad, any_bad;
  logic            fifo_empty, fifo_full, pop;
  logic            latch_en, check_en, push_en, busy;
  logic            wr_en, push_lost;

  assign frame_evt = bus.frame_valid & ~fv_q;

  assign start_bad = shadow_q[0];
  assign stop_bad  = ~shadow_q[10];
`ifdef RX_PARITY_EN
  logic parity_err_q, parity_err_d;
  // Reduction over data + parity bit is 0 for a good even-parity frame.
  assign par_bad = (^shadow_q[9:1]) ^ PARITY_ODD[0];
`else
  assign par_bad = 1'b0;
`endif
  assign any_bad = start_bad | stop_bad | par_bad;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop        = ~fifo_empty & bus.rd_ready;

  // FSM: state register
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_evt) state_d = CHECK;
      CHECK:   state_d = any_bad ? DROP : PUSH;
      PUSH:    state_d = IDLE;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = 1'b1;
    latch_en = 1'b0;
    check_en = 1'b0;
    push_en  = 1'b0;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        latch_en = frame_evt;
      end
      CHECK:   check_en = 1'b1;
      PUSH:    push_en  = 1'b1;
      default: ;
    endcase
  end

  // A same-cycle pop frees the slot, so a push to a full FIFO still lands.
  assign wr_en     = push_en & (~fifo_full | pop);
  assign push_lost = push_en & fifo_full & ~pop;

  always_comb begin
    fv_d     = bus.frame_valid;
    shadow_d = latch_en ? bus.frame_data : shadow_q;
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = shadow_q[8:1];
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    // Sticky flags: a set in the same cycle as err_clr wins.
    frame_err_d = (frame_err_q & ~bus.err_clr) | (check_en & (start_bad | stop_bad));
    overrun_d   = (overrun_q & ~bus.err_clr) | push_lost | (frame_evt & (state_q != IDLE));
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q        <= 1'b0;
      shadow_q    <= 11'h7FF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      fv_q        <= fv_d;
      shadow_q    <= shadow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
    end
  end

`ifdef RX_PARITY_EN
  always_comb begin
    parity_err_d = (parity_err_q & ~bus.err_clr) | (check_en & par_bad);
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rd_valid   = ~fifo_empty;
  assign bus.fifo_count = wr_ptr_q - rd_ptr_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy;

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller that sits directly behind the UART RX serial-to-parallel shifter. It latches each completed 11-bit frame, checks start, stop and (optionally) parity bits, and pushes good data bytes into a small FIFO. The FIFO drains through a valid/ready handshake to the host side. It also keeps sticky error/overrun status for the register block.

## Interface
Parameters:
- FIFO_DEPTH, 4: FIFO entries; power of two, 2..16.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when parity checking is compiled in.

Ports:
- baud_clk, in, 1: oversampling clock (16x bit rate).
- rst_n, in, 1: reset; asynchronous, active-low.
- frame_valid, in, 1: frame-complete strobe from the shifter; level, may stay high several cycles.
- frame_data, in, 11: captured frame; [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
- rd_ready, in, 1: consumer accepts the head byte.
- err_clr, in, 1: clears all sticky flags.
- rd_data, out, 8: FIFO head byte.
- rd_valid, out, 1: FIFO non-empty.
- fifo_count, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- frame_err, out, 1: sticky; a frame had start!=0 or stop!=1.
- parity_err, out, 1: sticky; a parity mismatch was detected.
- overrun, out, 1: sticky; a frame was lost.
- busy, out, 1: FSM not in IDLE.

## Operation
- Edge detect: a new frame is the rising edge of frame_valid (registered previous value). A level held high produces exactly one frame event.
- FSM states: IDLE, CHECK, PUSH, DROP.
  - IDLE: on a frame event, latch frame_data into a shadow register and go to CHECK.
  - CHECK: evaluate the frame.
    - start_bad = shadow[0]; stop_bad = ~shadow[10].
    - par_bad = ^shadow[9:1] ^ PARITY_ODD (parity build only).
    - If any check fails: set the matching sticky flag(s), go to DROP.
    - Otherwise go to PUSH.
  - PUSH: write shadow[8:1] into the FIFO if it is not full. If it is full, discard the byte and set overrun. Return to IDLE.
  - DROP: write nothing. Return to IDLE.
- A frame event in any state other than IDLE is discarded and sets overrun. The frame being processed is unaffected.
- FIFO: circular buffer with pointers one bit wider than the index. Full when the indexes match and the MSBs differ; empty when the pointers are equal. Pointers wrap modulo 2*FIFO_DEPTH.
- Pop: a pop occurs when rd_valid && rd_ready; the read pointer advances.
- Push to a full FIFO with a same-cycle pop: the push is accepted, the count stays at FIFO_DEPTH, and overrun is not set.
- Push to an empty FIFO with rd_ready high: no bypass. The byte appears on rd_data the next cycle.
- rd_data is combinational from the head entry. When empty its value is the last head byte, don't-care.
- Sticky flags: err_clr clears them. If a set and err_clr occur in the same cycle, the set wins.

## Timing
- Reset values: rd_valid=0, fifo_count=0, rd_data=8'h00, frame_err=0, parity_err=0, overrun=0, busy=0. The FSM resets to IDLE, both pointers to 0, and the shadow register to 11'h7FF.
- Latency: frame_valid rises at edge N. The shadow is latched at edge N+1 (state becomes CHECK, busy=1). PUSH is entered at N+2. The FIFO write occurs at N+3: rd_valid=1, fifo_count increments, busy=0.
- Error flags assert at edge N+2, on leaving CHECK.
- A frame is processed in 3 cycles. The shifter delivers frames at least 16*11 cycles apart, so non-IDLE frame events occur only on a fault.
- Reset mid-operation: any state immediately returns to IDLE. The FIFO contents are discarded and the partial frame is lost, with no flag set.

## Configuration
- RX_PARITY_EN defined: parity is checked per PARITY_ODD; parity_err is live and par_bad causes DROP.
- RX_PARITY_EN undefined: bit [9] is ignored, no parity logic is built, and parity_err is tied to 0.

## Test plan
- Good frame, even parity: frame_data=11'b1_0_01010101_0 (data 8'h55, parity 0), pulse frame_valid, rd_ready=0. Expect rd_valid=1 and rd_data=8'h55 three cycles after the rise, fifo_count=1, no flags.
- Stop/start errors: stop bit 0 gives frame_err=1 and no push. Then start bit 1 leaves frame_err still 1. Pulse err_clr: frame_err=0, fifo_count=0.
- Parity (RX_PARITY_EN, PARITY_ODD=0): data 8'h01 with parity 0 gives parity_err=1 and a drop. Rebuilt without the macro, the same frame is pushed and parity_err stays 0.
- FIFO full: push 5 good frames (8'h10..8'h14) with rd_ready=0 at depth 4. Expect fifo_count=4 and overrun=1. Reading drains 8'h10..8'h13 in order, then rd_valid=0.
- Full with simultaneous pop: with FIFO full, hold rd_ready=1 so the PUSH cycle coincides with a pop. Expect the byte accepted, fifo_count=4, overrun=0. Pointer wrap is exercised over 20 frames with data order intact.
- Busy collision and reset: a second frame_valid rise one cycle after the first gives overrun=1 and only the first byte pushed. Asserting rst_n low while in CHECK gives all outputs at reset values and no push after release.
